// File: rtl/sram_responder.sv
// Single-port 32-bit word SRAM behind a CPU core SRAM port, with byte write enables.
// Define SRAM_RESP_WAIT_EN to insert WAIT_CYCLES stall cycles per request; otherwise it has single-cycle latency.
module sram_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        dbg_busy_o
);

  localparam int DEPTH = 1 << ADDR_W;

  // Handshake: the core presents a request with en=1. The request is accepted
  // when the responder is idle, and the core holds en/wen/addr/wdata stable
  // while stall=1. The cycle in which stall drops is the completion cycle.
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic [31:0]       rdata_q, rdata_d;
  logic              unused_addr_bits;

  assign idx              = addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};
  assign rdata            = rdata_q;

  // Writes commit once, at the acceptance edge. Memory is never reset.
  always_ff @(posedge clk) begin
    if (accept && (wen != 4'd0)) begin
      for (int b = 0; b < 4; b++) begin
        if (wen[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

`ifdef SRAM_RESP_WAIT_EN
  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              rd_q, rd_d;
  logic              stall_c;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    accept  = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            if (wen == 4'd0) rdata_d = mem[idx];
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
            idx_d   = idx;
            rd_d    = (wen == 4'd0);
            stall_c = 1'b1;
          end
        end
      end
      BUSY: begin
        stall_c = (cnt_q != 4'd0);
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Completion cycle: read uses the index latched at acceptance.
          state_d = IDLE;
          if (rd_q) rdata_d = mem[idx_q];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The core keeps en high during reset, so stall is gated to read 0 there.
  assign stall      = stall_c & resetn;
  assign dbg_busy_o = (state_q == BUSY);
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;

  assign accept     = en;
  assign stall      = 1'b0;
  assign dbg_busy_o = 1'b0;

  always_comb begin
    rdata_d = rdata_q;
    if (en && (wen == 4'd0)) rdata_d = mem[idx];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdata_q <= 32'h0;
    else         rdata_q <= rdata_d;
  end
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: transaction-level memory model with expected-read queue,
// per-cycle compare of stall/rdata/busy, directed literal cases and randomized traffic.
module tb_sram_responder;

  localparam int ADDR_W      = 12;
  localparam int WAIT_CYCLES = 2;
`ifdef SRAM_RESP_WAIT_EN
  localparam int N = WAIT_CYCLES;
`else
  localparam int N = 0;
`endif

  // clock / reset
  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        stall;
  logic        dbg_busy;

  always #5 clk = ~clk;

  sram_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .en         (en),
    .wen        (wen),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .dbg_busy_o (dbg_busy)
  );

  // scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  logic        check_en = 1'b0;
  logic        exp_stall = 1'b0;
  logic        exp_busy = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_m [1 << ADDR_W];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check32("stall", {31'd0, stall}, {31'd0, exp_stall});
      check32("busy", {31'd0, dbg_busy}, {31'd0, exp_busy});
      check32("rdata", rdata, exp_rdata);
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] w);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (w[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // driver tasks: entered and left at posedge+1; request is held for N+1 cycles
  task automatic do_req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    int i;
    i = int'(a[ADDR_W+1:2]);
    en = 1'b1; wen = w; addr = a; wdata = d;
    if (w != 4'd0) mem_m[i] = merge(mem_m[i], d, w);
    else exp_q.push_back(mem_m[i]);
    for (int k = 0; k <= N; k++) begin
      exp_stall = (k < N);
      exp_busy  = (k >= 1);
      @(posedge clk); #1;
    end
    if (w == 4'd0) exp_rdata = exp_q.pop_front();
    en = 1'b0; wen = 4'd0; exp_stall = 1'b0; exp_busy = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic read_lit(input string name, input logic [31:0] a, input logic [31:0] lit);
    do_req(4'd0, a, 32'd0);
    check32(name, rdata, lit);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    #1 resetn = 1'b0;
    #2;
    check32("reset_rdata", rdata, 32'h0);
    check32("reset_stall", {31'd0, stall}, 32'd0);
    check32("reset_busy", {31'd0, dbg_busy}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    check_en = 1'b1;

    do_req(4'hF, 32'h10, 32'h12345678);
    read_lit("rd_0x10", 32'h10, 32'h12345678);

    do_req(4'hF, 32'h20, 32'hFFFFFFFF);
    do_req(4'h1, 32'h20, 32'h000000AB);
    read_lit("lane0", 32'h20, 32'hFFFFFFAB);
    do_req(4'h4, 32'h20, 32'h00CD0000);
    read_lit("lane2", 32'h20, 32'hFFCDFFAB);

    do_req(4'd0, 32'h10, 32'd0);
    check32("b2b_first", rdata, 32'h12345678);
    do_req(4'd0, 32'h20, 32'd0);
    check32("b2b_second", rdata, 32'hFFCDFFAB);
    idle(1);

    do_req(4'hF, 32'h4004, 32'hCAFEF00D);
    read_lit("alias", 32'h0004, 32'hCAFEF00D);

    // reset in the first cycle of a held read (the acceptance cycle)
    check_en = 1'b0;
    en = 1'b1; wen = 4'd0; addr = 32'h10;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check32("rst_mid_stall", {31'd0, stall}, 32'd0);
    check32("rst_mid_rdata", rdata, 32'h0);
    check32("rst_mid_busy", {31'd0, dbg_busy}, 32'd0);
    @(posedge clk); #1;
    en = 1'b0;
    resetn = 1'b1;
    exp_rdata = 32'h0;
    exp_stall = 1'b0;
    exp_busy = 1'b0;
    check_en = 1'b1;
    idle(1);
    read_lit("after_reset", 32'h0004, 32'hCAFEF00D);

    // randomized traffic over 16 words, random upper/low address bits for aliasing
    for (int i = 0; i < 16; i++) do_req(4'hF, 32'(i * 4), $urandom);
    for (int t = 0; t < 300; t++) begin
      a = $urandom;
      a[ADDR_W+1:2] = 12'($urandom_range(0, 15));
      w = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      do_req(w, a, $urandom);
      idle($urandom_range(0, 2));
    end

    idle(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
